// File: rtl/input_select_ctrl.sv
// Local/remote antenna selector with remote watchdog fallback, per-channel
// break-before-make sequencing and a cross-channel antenna interlock.
module input_select_ctrl #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned TIMEOUT  = 1000000,
    parameter int unsigned DEAD_CYC = 5000
) (
    input  logic                    I_CLK,
    input  logic                    I_RST,
    input  logic [N_CH*SEL_W-1:0]   I_local,
    input  logic [N_CH*SEL_W-1:0]   I_remote_sel,
    input  logic                    I_remote,
    input  logic                    I_remote_valid,
    output logic [N_CH*SEL_W-1:0]   O_sel,
    output logic                    O_remote_active,
    output logic [N_CH-1:0]         O_busy,
    output logic [N_CH-1:0]         O_conflict
);

    localparam int unsigned DC_W = $clog2(DEAD_CYC + 1);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [DC_W-1:0] DC_LOAD = DC_W'(DEAD_CYC);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT);

    typedef enum logic {ST_STABLE, ST_BREAK} state_t;

    logic [WD_W-1:0]  wd;
    state_t           state [N_CH];
    logic [SEL_W-1:0] tgt   [N_CH];
    logic [SEL_W-1:0] sel_q [N_CH];
    logic [SEL_W-1:0] cand  [N_CH];
    logic [DC_W-1:0]  dc    [N_CH];
    logic [N_CH-1:0]  blocked;

    // Watchdog starts expired so remote is ignored until the first strobe.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            wd              <= '0;
            O_remote_active <= 1'b0;
        end else begin
            if (I_remote_valid)
                wd <= WD_LOAD;
            else if (wd != '0)
                wd <= wd - 1'b1;
            O_remote_active <= I_remote && (wd != '0);
        end
    end

    always_comb begin
        O_sel   = '0;
        blocked = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand[k] = O_remote_active ? I_remote_sel[k*SEL_W +: SEL_W]
                                      : I_local[k*SEL_W +: SEL_W];
            O_sel[k*SEL_W +: SEL_W] = sel_q[k];
            // Committed antennas of any other channel block; pending makes
            // block only higher-index channels so the lower index wins ties.
            for (int unsigned j = 0; j < N_CH; j++) begin
                if (j != k && sel_q[j] == tgt[k])
                    blocked[k] = 1'b1;
                if (j < k && state[j] == ST_BREAK && tgt[j] == tgt[k])
                    blocked[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (I_RST) begin
                state[k]      <= ST_STABLE;
                sel_q[k]      <= '0;
                tgt[k]        <= '0;
                dc[k]         <= '0;
                O_busy[k]     <= 1'b0;
                O_conflict[k] <= 1'b0;
            end else begin
                case (state[k])
                    ST_STABLE: begin
                        if (cand[k] != sel_q[k]) begin
                            sel_q[k] <= '0;
                            if (cand[k] != '0) begin
                                tgt[k]    <= cand[k];
                                dc[k]     <= DC_LOAD;
                                state[k]  <= ST_BREAK;
                                O_busy[k] <= 1'b1;
                            end
                        end
                    end
                    ST_BREAK: begin
                        if (cand[k] != tgt[k]) begin
                            O_conflict[k] <= 1'b0;
                            if (cand[k] == '0) begin
                                state[k]  <= ST_STABLE;
                                O_busy[k] <= 1'b0;
                            end else begin
                                tgt[k] <= cand[k];
                                dc[k]  <= DC_LOAD;
                            end
                        end else if (dc[k] != '0) begin
                            dc[k] <= dc[k] - 1'b1;
                        end else if (blocked[k]) begin
                            O_conflict[k] <= 1'b1;
                        end else begin
                            sel_q[k]      <= tgt[k];
                            state[k]      <= ST_STABLE;
                            O_busy[k]     <= 1'b0;
                            O_conflict[k] <= 1'b0;
                        end
                    end
                    default: state[k] <= ST_STABLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_input_select_ctrl.sv
// Directed bench for input_select_ctrl: two channels, 3-bit codes,
// TIMEOUT 20 and DEAD_CYC 4, with hand-computed expectations.
module tb_input_select_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] loc;
    logic [5:0] rsel;
    logic       rem;
    logic       rv;
    logic [5:0] sel;
    logic       act;
    logic [1:0] busy;
    logic [1:0] conf;

    int checks   = 0;
    int failures = 0;

    input_select_ctrl #(
        .N_CH(2),
        .SEL_W(3),
        .TIMEOUT(20),
        .DEAD_CYC(4)
    ) dut (
        .I_CLK(clk),
        .I_RST(rst),
        .I_local(loc),
        .I_remote_sel(rsel),
        .I_remote(rem),
        .I_remote_valid(rv),
        .O_sel(sel),
        .O_remote_active(act),
        .O_busy(busy),
        .O_conflict(conf)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; loc = '0; rsel = '0; rem = 1'b0; rv = 1'b0;
        step(2);
        chk("rst_sel", sel, 0);
        chk("rst_act", act, 0);
        chk("rst_busy", busy, 0);
        chk("rst_conf", conf, 0);

        // Local make of code 3 on channel 0
        rst = 1'b0; loc = {3'd0, 3'd3};
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t1_break_sel", sel, 0);
            chk("t1_break_busy", busy, 2'b01);
        end
        step(1);
        chk("t1_make_sel", sel, 6'd3);
        chk("t1_make_busy", busy, 0);
        chk("t1_act", act, 0);

        // Remote take-over then watchdog expiry
        rem = 1'b1; rsel = {3'd0, 3'd5}; rv = 1'b1;
        step(1); rv = 1'b0;
        chk("t2_act_lat", act, 0);
        chk("t2_sel_hold", sel, 6'd3);
        step(1);
        chk("t2_act_on", act, 1);
        chk("t2_sel_hold2", sel, 6'd3);
        step(1);
        chk("t2_break_sel", sel, 0);
        chk("t2_break_busy", busy, 2'b01);
        step(4);
        chk("t2_dead_sel", sel, 0);
        chk("t2_dead_busy", busy, 2'b01);
        step(1);
        chk("t2_make_sel", sel, 6'd5);
        chk("t2_make_busy", busy, 0);
        step(13);
        chk("t2_act_last", act, 1);
        chk("t2_sel_remote", sel, 6'd5);
        step(1);
        chk("t2_act_expire", act, 0);
        step(1);
        chk("t2_fb_break_sel", sel, 0);
        chk("t2_fb_break_busy", busy, 2'b01);
        step(4);
        chk("t2_fb_dead_sel", sel, 0);
        step(1);
        chk("t2_fb_make_sel", sel, 6'd3);
        chk("t2_fb_busy", busy, 0);
        rem = 1'b0;

        // Interlock: channel 1 wants channel 0's antenna
        loc = {3'd0, 3'd2};
        step(6);
        chk("t3_k0_sel", sel, 6'd2);
        loc = {3'd2, 3'd2};
        step(5);
        chk("t3_dead_sel", sel, 6'd2);
        chk("t3_dead_busy", busy, 2'b10);
        chk("t3_dead_conf", conf, 0);
        step(1);
        chk("t3_conf", conf, 2'b10);
        chk("t3_conf_sel", sel, 6'd2);
        chk("t3_conf_busy", busy, 2'b10);
        step(3);
        chk("t3_conf_hold", conf, 2'b10);
        chk("t3_conf_hold_sel", sel, 6'd2);
        loc = {3'd2, 3'd0};
        step(1);
        chk("t3_k0_off_sel", sel, 0);
        chk("t3_k0_off_conf", conf, 2'b10);
        step(1);
        chk("t3_k1_make_sel", sel, {3'd2, 3'd0});
        chk("t3_k1_make_conf", conf, 0);
        chk("t3_k1_make_busy", busy, 0);

        // Simultaneous request of the same antenna
        loc = '0;
        step(1);
        chk("t4_clear_sel", sel, 0);
        loc = {3'd6, 3'd6};
        step(5);
        chk("t4_dead_sel", sel, 0);
        chk("t4_dead_busy", busy, 2'b11);
        chk("t4_dead_conf", conf, 0);
        step(1);
        chk("t4_make_sel", sel, 6'd6);
        chk("t4_make_conf", conf, 2'b10);
        chk("t4_make_busy", busy, 2'b10);
        step(2);
        chk("t4_hold_sel", sel, 6'd6);
        chk("t4_hold_conf", conf, 2'b10);

        // Retarget mid-break, then abort to off
        loc = '0;
        step(1);
        chk("t5_clear_sel", sel, 0);
        chk("t5_clear_busy", busy, 0);
        chk("t5_clear_conf", conf, 0);
        loc = {3'd0, 3'd3};
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t5_b3_sel", sel, 0);
            chk("t5_b3_busy", busy, 2'b01);
        end
        loc = {3'd0, 3'd4};
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t5_b4_sel", sel, 0);
            chk("t5_b4_busy", busy, 2'b01);
        end
        step(1);
        chk("t5_make4_sel", sel, 6'd4);
        chk("t5_make4_busy", busy, 0);
        loc = {3'd0, 3'd3};
        step(2);
        chk("t5_b_sel", sel, 0);
        chk("t5_b_busy", busy, 2'b01);
        loc = '0;
        step(1);
        chk("t5_abort_sel", sel, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_conf", conf, 0);
        step(1);
        chk("t5_abort_hold", busy, 0);

        // Reset mid-break discards remote until a fresh strobe
        rem = 1'b1; rsel = {3'd0, 3'd5}; rv = 1'b1;
        step(1); rv = 1'b0;
        step(1);
        chk("t6_act_on", act, 1);
        step(1);
        chk("t6_break_busy", busy, 2'b01);
        chk("t6_break_sel", sel, 0);
        rst = 1'b1;
        step(1);
        chk("t6_rst_sel", sel, 0);
        chk("t6_rst_act", act, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_conf", conf, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("t6_idle_act", act, 0);
            chk("t6_idle_sel", sel, 0);
            chk("t6_idle_busy", busy, 0);
        end
        rv = 1'b1;
        step(1); rv = 1'b0;
        chk("t6_restrobe_lat", act, 0);
        step(1);
        chk("t6_restrobe_act", act, 1);
        step(1);
        chk("t6_rebreak_busy", busy, 2'b01);
        step(5);
        chk("t6_remake_sel", sel, 6'd5);
        chk("t6_remake_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
